// File: rtl/sm_move_ctrl.sv
// sm_move_ctrl: stepper move sequencer with trapezoid/triangle speed ramp.
// Drives pulse generator period/enable, counts steps, supports soft abort.
// Ports:
//   clk, rst            clock, sync active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while idle)
//   cmd_steps/dir/per_min  move length, direction, cruise period
//   abort               soft stop request (level)
//   drv_step            1-clk step pulse back from the pulse generator
//   drv_enable/drv_dir  pulse generator enable and direction
//   per_n/per_load      period value and its capture strobe
//   busy/done           move in progress / 1-clk end-of-move pulse
//   steps_done          steps issued in current or last move
module sm_move_ctrl #(
  parameter int PER_W     = 17,
  parameter int CNT_W     = 24,
  parameter int PER_START = 1000,
  parameter int ACC_DEC   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_per_min,
  input  logic             abort,
  input  logic             drv_step,
  output logic             drv_enable,
  output logic             drv_dir,
  output logic [PER_W-1:0] per_n,
  output logic             per_load,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_done
);

  localparam logic [PER_W-1:0] P_START = PER_W'(PER_START);
  localparam logic [PER_W:0]   P_ACC   = (PER_W+1)'(ACC_DEC);
  localparam logic [PER_W-1:0] P_TWO   = PER_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] steps_tgt;
  logic [CNT_W-1:0] ramp_cnt;
  logic [PER_W-1:0] per_min;
  logic             aborting;

  logic             step_ev;
  logic [CNT_W-1:0] steps_nx;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] ramp_up;
  logic [CNT_W-1:0] ramp_dn;
  logic [PER_W:0]   per_sum;
  logic [PER_W-1:0] per_dn;
  logic [PER_W-1:0] per_up;
  logic [PER_W-1:0] pmin_c;
  logic             abort_any;

  // Steps are counted before transitions, so rem reflects this edge's step.
  always_comb begin
    step_ev   = drv_step & drv_enable;
    steps_nx  = steps_done + CNT_W'(step_ev);
    rem       = steps_tgt - steps_nx;
    ramp_up   = ramp_cnt + 1'b1;
    ramp_dn   = (ramp_cnt == '0) ? '0 : ramp_cnt - 1'b1;
    abort_any = aborting | abort;
    pmin_c    = (cmd_per_min < P_TWO) ? P_TWO : cmd_per_min;
    per_sum   = {1'b0, per_min} + P_ACC;
    per_dn    = ({1'b0, per_n} > per_sum) ?
                PER_W'({1'b0, per_n} - P_ACC) : per_min;
    per_up    = (({1'b0, per_n} + P_ACC) >= {1'b0, P_START}) ?
                P_START : PER_W'({1'b0, per_n} + P_ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      drv_enable <= 1'b0;
      drv_dir    <= 1'b0;
      per_n      <= P_START;
      per_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_done <= '0;
      steps_tgt  <= '0;
      ramp_cnt   <= '0;
      per_min    <= P_START;
      aborting   <= 1'b0;
    end else begin
      per_load <= 1'b0;
      done     <= 1'b0;
      if (step_ev)
        steps_done <= steps_nx;
      unique case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            steps_tgt  <= cmd_steps;
            drv_dir    <= cmd_dir;
            per_min    <= pmin_c;
            steps_done <= '0;
            ramp_cnt   <= '0;
            aborting   <= 1'b0;
            if (cmd_steps == '0) begin
              state <= S_FINISH;
            end else begin
              drv_enable <= 1'b1;
              busy       <= 1'b1;
              per_n      <= P_START;
              per_load   <= 1'b1;
              state      <= (pmin_c >= P_START) ? S_CRUISE : S_ACCEL;
            end
          end
        end
        S_ACCEL: begin
          if (step_ev) begin
            ramp_cnt <= ramp_up;
            per_n    <= per_dn;
            per_load <= (per_dn != per_n);
            if (rem == '0) begin
              drv_enable <= 1'b0;
              busy       <= 1'b0;
              state      <= S_FINISH;
            end else if (abort || rem <= ramp_up) begin
              aborting <= abort;
              state    <= S_DECEL;
            end else if (per_dn == per_min) begin
              state <= S_CRUISE;
            end
          end else if (abort) begin
            aborting <= 1'b1;
            if (ramp_cnt == '0) begin
              drv_enable <= 1'b0;
              busy       <= 1'b0;
              state      <= S_FINISH;
            end else begin
              state <= S_DECEL;
            end
          end
        end
        S_CRUISE: begin
          if (step_ev && rem == '0) begin
            drv_enable <= 1'b0;
            busy       <= 1'b0;
            state      <= S_FINISH;
          end else if (abort) begin
            aborting <= 1'b1;
            if (ramp_cnt == '0) begin
              drv_enable <= 1'b0;
              busy       <= 1'b0;
              state      <= S_FINISH;
            end else begin
              state <= S_DECEL;
            end
          end else if (step_ev && rem <= ramp_cnt) begin
            state <= S_DECEL;
          end
        end
        S_DECEL: begin
          if (abort)
            aborting <= 1'b1;
          if (step_ev) begin
            ramp_cnt <= ramp_dn;
            per_n    <= per_up;
            per_load <= (per_up != per_n);
            if (rem == '0 || (abort_any && ramp_dn == '0)) begin
              drv_enable <= 1'b0;
              busy       <= 1'b0;
              state      <= S_FINISH;
            end
          end else if (abort_any && ramp_cnt == '0) begin
            drv_enable <= 1'b0;
            busy       <= 1'b0;
            state      <= S_FINISH;
          end
        end
        S_FINISH: begin
          drv_enable <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          per_n      <= P_START;
          per_load   <= (per_n != P_START);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_move_ctrl.sv
// tb_sm_move_ctrl: directed bench for the move sequencer.
// Drives step pulses by hand and checks period profile and handshakes.
module tb_sm_move_ctrl;

  localparam int PER_W = 17;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic             cmd_dir = 1'b0;
  logic [PER_W-1:0] cmd_per_min = '0;
  logic             abort = 1'b0;
  logic             drv_step = 1'b0;
  logic             drv_enable;
  logic             drv_dir;
  logic [PER_W-1:0] per_n;
  logic             per_load;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_done;

  int n_cmp = 0;
  int n_bad = 0;
  int loads = 0;
  int tri_exp [6] = '{900, 800, 700, 800, 900, 1000};

  sm_move_ctrl #(
    .PER_W(PER_W),
    .CNT_W(CNT_W),
    .PER_START(1000),
    .ACC_DEC(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .cmd_dir(cmd_dir),
    .cmd_per_min(cmd_per_min),
    .abort(abort),
    .drv_step(drv_step),
    .drv_enable(drv_enable),
    .drv_dir(drv_dir),
    .per_n(per_n),
    .per_load(per_load),
    .busy(busy),
    .done(done),
    .steps_done(steps_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_one();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    if (per_load)
      loads++;
  endtask

  task automatic issue(input int steps, input logic dir,
                       input int pmin);
    cmd_steps   = CNT_W'(steps);
    cmd_dir     = dir;
    cmd_per_min = PER_W'(pmin);
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    // reset state
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_en", drv_enable, 0);
    check("rst_per", per_n, 1000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps", steps_done, 0);

    // trapezoid
    issue(20, 1'b1, 500);
    check("trap_en", drv_enable, 1);
    check("trap_dir", drv_dir, 1);
    check("trap_busy", busy, 1);
    check("trap_ld0", per_load, 1);
    check("trap_rdy", cmd_ready, 0);
    loads = 0;
    for (int i = 1; i <= 20; i++) begin
      step_one();
      check($sformatf("trap_per%0d", i), per_n,
            (i <= 5) ? 1000 - 100 * i :
            (i <= 15) ? 500 : 500 + 100 * (i - 15));
      check($sformatf("trap_cnt%0d", i), steps_done, i);
    end
    check("trap_en_off", drv_enable, 0);
    wait_done();
    check("trap_steps", steps_done, 20);
    check("trap_loads", loads, 10);
    check("trap_rdy_done", cmd_ready, 0);
    tick();
    check("trap_rdy_after", cmd_ready, 1);
    check("trap_done_off", done, 0);

    // triangle
    issue(6, 1'b0, 500);
    for (int i = 0; i < 6; i++) begin
      step_one();
      check($sformatf("tri_per%0d", i + 1), per_n, tri_exp[i]);
    end
    wait_done();
    check("tri_steps", steps_done, 6);
    tick();

    // zero-length move
    issue(0, 1'b0, 500);
    check("zero_en", drv_enable, 0);
    check("zero_busy", busy, 0);
    check("zero_done_early", done, 0);
    tick();
    check("zero_done", done, 1);
    check("zero_en2", drv_enable, 0);
    tick();
    check("zero_rdy", cmd_ready, 1);

    // cruise period slower than start: no ramp
    issue(3, 1'b0, 1200);
    check("slow_per", per_n, 1000);
    check("slow_ld", per_load, 1);
    loads = 0;
    for (int i = 1; i <= 3; i++) begin
      step_one();
      check($sformatf("slow_per%0d", i), per_n, 1000);
    end
    wait_done();
    check("slow_loads", loads, 0);
    check("slow_steps", steps_done, 3);
    tick();

    // abort in cruise
    issue(100, 1'b0, 500);
    for (int i = 1; i <= 10; i++)
      step_one();
    check("ab_cruise_per", per_n, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_en", drv_enable, 1);
    check("ab_per_hold", per_n, 500);
    for (int i = 1; i <= 5; i++) begin
      step_one();
      check($sformatf("ab_per%0d", i), per_n, 500 + 100 * i);
    end
    check("ab_en_off", drv_enable, 0);
    wait_done();
    check("ab_steps", steps_done, 15);
    tick();

    // command held during a move; step while disabled ignored
    cmd_steps   = 24'd2;
    cmd_per_min = 17'd500;
    cmd_valid   = 1'b1;
    tick();
    cmd_steps = 24'd7;
    check("hold_rdy", cmd_ready, 0);
    step_one();
    check("hold_cnt1", steps_done, 1);
    check("hold_busy", busy, 1);
    step_one();
    wait_done();
    check("hold_rdy_done", cmd_ready, 0);
    tick();
    check("hold_rdy_after", cmd_ready, 1);
    check("hold_steps", steps_done, 2);
    check("hold_idle", busy, 0);
    tick();
    cmd_valid = 1'b0;
    check("hold_reacc", busy, 1);
    check("hold_clr", steps_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab0_en", drv_enable, 0);
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    check("ab0_done", done, 1);
    check("ab0_nostep", steps_done, 0);
    tick();

    // reset in the middle of accel
    issue(50, 1'b1, 300);
    step_one();
    step_one();
    check("mid_per", per_n, 800);
    rst = 1'b1;
    tick(); tick(); tick();
    check("mid_en", drv_enable, 0);
    check("mid_per_rst", per_n, 1000);
    check("mid_dir", drv_dir, 0);
    check("mid_steps", steps_done, 0);
    rst = 1'b0;
    tick();
    check("mid_done", done, 0);
    check("mid_rdy", cmd_ready, 1);
    check("mid_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
